// File: rtl/instr_fetcher_pkg.sv
// Shared types and helpers for the instruction fetch front-end.
// Holds the fetch FSM encoding and PC alignment.
package instr_fetcher_pkg;

    typedef enum logic [2:0] {
        FetchIdle    = 3'd0,
        FetchReq     = 3'd1,
        FetchHold    = 3'd2,
        FetchWaitPc  = 3'd3,
        FetchDiscard = 3'd4
    } fetch_state_e;

    // PCs are halfword aligned; bit 0 is forced low on every update.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:1], 1'b0};
    endfunction

endpackage

// File: rtl/instr_fetcher.sv
// Fetch stage: one ICache request at a time, 16/32-bit classification,
// hold until issued, redirect on issue (predict_pc) or flush (rob_new_pc).
module instr_fetcher
    import instr_fetcher_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        icache_req,
    output logic [31:0] icache_addr,
    input  logic        icache_ready,
    input  logic [31:0] icache_data,
    output logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] instr_addr_out,
    output logic        is_compressed,
    input  logic        dec_issue_now,
    input  logic        dec_issued,
    input  logic [31:0] predict_pc,
    input  logic        rob_clear,
    input  logic [31:0] rob_new_pc
);

    function automatic logic is_rvc(input logic [1:0] op);
        return op != 2'b11;
    endfunction

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         req_q, req_d;
    logic [31:0]  addr_q, addr_d;
    logic         ready_q, ready_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  iaddr_q, iaddr_d;
    logic         comp_q, comp_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        addr_d  = addr_q;
        ready_d = ready_q;
        instr_d = instr_q;
        iaddr_d = iaddr_q;
        comp_d  = comp_q;

        if (rob_clear) begin
            ready_d = 1'b0;
            pc_d    = align_pc(rob_new_pc);
            // An in-flight request must still complete; its data is dropped in FetchDiscard.
            if ((state_q == FetchReq || state_q == FetchDiscard) && !icache_ready) begin
                state_d = FetchDiscard;
            end else begin
                state_d = FetchReq;
                req_d   = 1'b1;
                addr_d  = pc_d;
            end
        end else begin
            case (state_q)
                FetchIdle: begin
                    state_d = FetchReq;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                end
                FetchReq: begin
                    if (icache_ready) begin
                        comp_d  = is_rvc(icache_data[1:0]);
                        instr_d = comp_d ? {16'b0, icache_data[15:0]} : icache_data;
                        iaddr_d = pc_q;
                        ready_d = 1'b1;
                        req_d   = 1'b0;
                        state_d = FetchHold;
                    end
                end
                FetchHold: begin
                    if (dec_issue_now) begin
                        ready_d = 1'b0;
                        state_d = FetchWaitPc;
                    end
                end
                FetchWaitPc: begin
                    if (dec_issued) begin
                        pc_d    = align_pc(predict_pc);
                        req_d   = 1'b1;
                        addr_d  = pc_d;
                        state_d = FetchReq;
                    end
                end
                FetchDiscard: begin
                    if (icache_ready) begin
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                        state_d = FetchReq;
                    end
                end
                default: state_d = FetchIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FetchIdle;
            pc_q    <= align_pc(RESET_PC);
            req_q   <= 1'b0;
            addr_q  <= 32'h0;
            ready_q <= 1'b0;
            instr_q <= 32'h0;
            iaddr_q <= 32'h0;
            comp_q  <= 1'b0;
        end else if (rdy) begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            ready_q <= ready_d;
            instr_q <= instr_d;
            iaddr_q <= iaddr_d;
            comp_q  <= comp_d;
        end
    end

    assign icache_req     = req_q;
    assign icache_addr    = addr_q;
    assign instr_ready    = ready_q;
    assign instr_out      = instr_q;
    assign instr_addr_out = iaddr_q;
    assign is_compressed  = comp_q;

endmodule

// File: tb/tb_instr_fetcher.sv
// Self-checking bench for instr_fetcher: directed fetch/issue/flush/freeze/reset
// sequence with a scoreboard of expected decoded instructions.
module tb_instr_fetcher;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_ready;
    logic [31:0] icache_data;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] instr_addr_out;
    logic        is_compressed;
    logic        dec_issue_now;
    logic        dec_issued;
    logic [31:0] predict_pc;
    logic        rob_clear;
    logic [31:0] rob_new_pc;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        comp;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic prev_ready = 1'b0;

    always #5 clk = ~clk;

    instr_fetcher #(.RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .icache_req    (icache_req),
        .icache_addr   (icache_addr),
        .icache_ready  (icache_ready),
        .icache_data   (icache_data),
        .instr_ready   (instr_ready),
        .instr_out     (instr_out),
        .instr_addr_out(instr_addr_out),
        .is_compressed (is_compressed),
        .dec_issue_now (dec_issue_now),
        .dec_issued    (dec_issued),
        .predict_pc    (predict_pc),
        .rob_clear     (rob_clear),
        .rob_new_pc    (rob_new_pc)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle ICache response; push the decoded result unless it should be dropped.
    task automatic respond(input logic [31:0] data, input logic [31:0] pc, input bit push);
        exp_t e;
        icache_ready = 1'b1;
        icache_data  = data;
        if (push) begin
            e.comp  = (data[1:0] != 2'b11);
            e.instr = e.comp ? {16'h0, data[15:0]} : data;
            e.addr  = pc;
            sb_q.push_back(e);
        end
        tick();
        icache_ready = 1'b0;
        icache_data  = 32'hDEAD_BEEF;
    endtask

    // Issue in cycle M, predict_pc in M+1; request must appear after the M+2 edge.
    task automatic issue_to(input logic [31:0] next_pc);
        dec_issue_now = 1'b1;
        tick();
        dec_issue_now = 1'b0;
        check_eq("issue_ready_low", {31'b0, instr_ready}, 32'd0);
        check_eq("issue_no_req", {31'b0, icache_req}, 32'd0);
        dec_issued = 1'b1;
        predict_pc = next_pc;
        tick();
        dec_issued = 1'b0;
        check_eq("redirect_req", {31'b0, icache_req}, 32'd1);
        check_eq("redirect_addr", icache_addr, next_pc);
    endtask

    // Scoreboard: each rising instr_ready must match the oldest expected response.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (rst && instr_ready && !prev_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected_ready", {31'b0, instr_ready}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("sb_instr", instr_out, e.instr);
                check_eq("sb_addr", instr_addr_out, e.addr);
                check_eq("sb_comp", {31'b0, is_compressed}, {31'b0, e.comp});
            end
        end
        prev_ready = rst ? instr_ready : 1'b0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held_instr;
        rst = 1'b0; rdy = 1'b1;
        icache_ready = 1'b0; icache_data = 32'h0;
        dec_issue_now = 1'b0; dec_issued = 1'b0; predict_pc = 32'h0;
        rob_clear = 1'b0; rob_new_pc = 32'h0;

        // 1. reset, first fetch at RESET_PC, compressed c.li
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_req", {31'b0, icache_req}, 32'd0);
        check_eq("rst_addr", icache_addr, 32'd0);
        check_eq("rst_ready", {31'b0, instr_ready}, 32'd0);
        check_eq("rst_instr", instr_out, 32'd0);
        rst = 1'b1;
        tick();
        check_eq("first_req", {31'b0, icache_req}, 32'd1);
        check_eq("first_addr", icache_addr, 32'h0);
        respond(32'h0000_4505, 32'h0, 1'b1);
        check_eq("first_latency", {31'b0, instr_ready}, 32'd1);
        check_eq("first_req_drop", {31'b0, icache_req}, 32'd0);

        // 2. addi at pc 4
        issue_to(32'h4);
        respond(32'h0050_0093, 32'h4, 1'b1);

        // 3. decoder stalls 5 cycles
        held_instr = instr_out;
        repeat (5) begin
            tick();
            check_eq("stall_ready", {31'b0, instr_ready}, 32'd1);
            check_eq("stall_instr", instr_out, held_instr);
            check_eq("stall_no_req", {31'b0, icache_req}, 32'd0);
        end
        issue_to(32'h8);

        // 4. flush in REQ, stale data arrives 3 cycles later
        rob_clear = 1'b1; rob_new_pc = 32'h100;
        tick();
        rob_clear = 1'b0;
        check_eq("discard_req_held", {31'b0, icache_req}, 32'd1);
        check_eq("discard_addr_held", icache_addr, 32'h8);
        repeat (2) tick();
        respond(32'h0000_0013, 32'h8, 1'b0);
        check_eq("discard_ready_low", {31'b0, instr_ready}, 32'd0);
        check_eq("refetch_addr", icache_addr, 32'h100);
        respond(32'h0000_0513, 32'h100, 1'b1);

        // 5. flush in HOLD together with issue; late dec_issued ignored
        rob_clear = 1'b1; rob_new_pc = 32'h100; dec_issue_now = 1'b1;
        tick();
        rob_clear = 1'b0; dec_issue_now = 1'b0;
        check_eq("clr_hold_ready", {31'b0, instr_ready}, 32'd0);
        check_eq("clr_hold_addr", icache_addr, 32'h100);
        dec_issued = 1'b1; predict_pc = 32'h300;
        tick();
        dec_issued = 1'b0;
        check_eq("ignored_issued_addr", icache_addr, 32'h100);
        check_eq("ignored_issued_req", {31'b0, icache_req}, 32'd1);

        // flush coincident with data in REQ: data dropped, new request next cycle
        rob_clear = 1'b1; rob_new_pc = 32'h41;
        respond(32'h0000_0001, 32'h100, 1'b0);
        rob_clear = 1'b0;
        check_eq("clr_ready_addr", icache_addr, 32'h40);
        check_eq("clr_ready_low", {31'b0, instr_ready}, 32'd0);

        // 6. rdy=0 freeze with icache_ready pulses
        rdy = 1'b0;
        repeat (4) begin
            respond(32'h1234_5678, 32'h40, 1'b0);
            check_eq("frz_req", {31'b0, icache_req}, 32'd1);
            check_eq("frz_addr", icache_addr, 32'h40);
            check_eq("frz_ready", {31'b0, instr_ready}, 32'd0);
        end
        rdy = 1'b1;
        respond(32'h1234_0001, 32'h40, 1'b1);

        // wrap-around pc, 32-bit instruction at the last halfword
        issue_to(32'hFFFF_FFFE);
        respond(32'h0000_0013, 32'hFFFF_FFFE, 1'b1);
        issue_to(32'h20);

        // async reset mid-DISCARD
        rob_clear = 1'b1; rob_new_pc = 32'h80;
        tick();
        rob_clear = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_eq("async_rst_req", {31'b0, icache_req}, 32'd0);
        check_eq("async_rst_addr", icache_addr, 32'd0);
        check_eq("async_rst_ready", {31'b0, instr_ready}, 32'd0);
        check_eq("async_rst_instr", instr_out, 32'd0);
        check_eq("async_rst_iaddr", instr_addr_out, 32'd0);
        check_eq("async_rst_comp", {31'b0, is_compressed}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check_eq("post_rst_addr", icache_addr, 32'h0);
        check_eq("post_rst_req", {31'b0, icache_req}, 32'd1);

        tick();
        check_eq("sb_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
